// File: rtl/i2c_arbiter_pkg.sv
// Shared definitions for the I2C requester arbiter.
// Holds the command encodings, the controller state encoding and the
// default transaction timeout used by i2c_arbiter.
package i2c_arbiter_pkg;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   req_i        - active request vector (one bit per requester)
//   last_grant_i - index of the previous owner; search starts just after it
//   winner_o     - index of the selected requester (0 when none active)
//   any_valid_o  - high when at least one request is active
module i2c_rr_picker #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      last_grant_i,
    output logic [1:0]      winner_o,
    output logic            any_valid_o
);

    logic [3:0] sum_s;
    logic [3:0] cand_s;
    logic       hit_s;
    logic       found_s;

    // Walk requesters starting after the last owner; first active one wins.
    always_comb begin
        winner_o = 2'd0;
        found_s  = 1'b0;
        sum_s    = 4'd0;
        cand_s   = 4'd0;
        hit_s    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            sum_s    = {2'b00, last_grant_i} + 4'(k);
            cand_s   = (sum_s >= 4'(NREQ)) ? (sum_s - 4'(NREQ)) : sum_s;
            hit_s    = !found_s && req_i[cand_s[1:0]];
            winner_o = hit_s ? cand_s[1:0] : winner_o;
            found_s  = found_s | hit_s;
        end
    end

    assign any_valid_o = |req_i;

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates NREQ requesters onto a single I2C master.
// A winner is picked round-robin in IDLE, its fields are latched onto the
// m_* outputs, m_rqt is held in ISSUE until the master's m_done falls or the
// timeout expires, then the owner receives a one-cycle req_ack with
// rsp_data/rsp_err.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_*_i             - per-requester valid/cmd/device/register/write data
//   req_ack_o           - one-cycle completion pulse to the owner
//   rsp_data_o/err_o    - read data / timeout flag, valid with req_ack_o
//   m_rqt_o, m_*_o      - request and latched fields towards the master
//   m_done_i/data_rd_i  - master completion (falling edge) and read data
//   busy_o, grant_id_o  - arbiter busy and current owner index
module i2c_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter int          NREQ        = 3,
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ-1:0]      req_cmd_i,
    input  logic [7*NREQ-1:0]    req_addr_dev_i,
    input  logic [16*NREQ-1:0]   req_addr_reg_i,
    input  logic [16*NREQ-1:0]   req_data_wr_i,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [7:0]           rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 m_rqt_o,
    output logic                 m_cmd_o,
    output logic [6:0]           m_addr_dev_o,
    output logic [7:0]           m_addr_reg_h_o,
    output logic [7:0]           m_addr_reg_l_o,
    output logic [7:0]           m_data_wr_h_o,
    output logic [7:0]           m_data_wr_l_o,
    input  logic                 m_done_i,
    input  logic [7:0]           m_data_rd_i,
    output logic                 busy_o,
    output logic [1:0]           grant_id_o
);

    localparam logic [1:0]      LAST_GRANT_RST = 2'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0       = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_e      state_q;
    logic [1:0]      grant_q;
    logic [1:0]      last_grant_q;
    logic [23:0]     cnt_q;
    logic            m_done_q;
    logic [NREQ-1:0] req_ack_q;
    logic [7:0]      rsp_data_q;
    logic            rsp_err_q;
    logic            m_rqt_q;
    logic            m_cmd_q;
    logic [6:0]      m_addr_dev_q;
    logic [15:0]     m_addr_reg_q;
    logic [15:0]     m_data_wr_q;
    logic            busy_q;

    logic [NREQ-1:0] pick_req_s;
    logic [1:0]      winner_s;
    logic            any_valid_s;
    logic            fall_s;
    logic            timeout_s;

    // The requester being acked still shows req_valid this cycle; hide it so
    // a requester that drops right after its ack is not granted again.
    assign pick_req_s = req_valid_i & ~req_ack_q;
    assign fall_s     = m_done_q & ~m_done_i;
    assign timeout_s  = (cnt_q == (TIMEOUT_CYC - 24'd1));

    i2c_rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i        (pick_req_s),
        .last_grant_i (last_grant_q),
        .winner_o     (winner_s),
        .any_valid_o  (any_valid_s)
    );

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= LAST_GRANT_RST;
            cnt_q        <= 24'd0;
            m_done_q     <= 1'b0;
            req_ack_q    <= '0;
            rsp_data_q   <= 8'h00;
            rsp_err_q    <= 1'b0;
            m_rqt_q      <= 1'b0;
            m_cmd_q      <= 1'b0;
            m_addr_dev_q <= 7'h00;
            m_addr_reg_q <= 16'h0000;
            m_data_wr_q  <= 16'h0000;
            busy_q       <= 1'b0;
        end else begin
            m_done_q  <= m_done_i;
            req_ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        grant_q      <= winner_s;
                        m_cmd_q      <= req_cmd_i[winner_s];
                        m_addr_dev_q <= req_addr_dev_i[7*int'(winner_s) +: 7];
                        m_addr_reg_q <= req_addr_reg_i[16*int'(winner_s) +: 16];
                        m_data_wr_q  <= req_data_wr_i[16*int'(winner_s) +: 16];
                        cnt_q        <= 24'd0;
                        m_rqt_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // A real completion takes priority over a coincident timeout.
                    if (fall_s) begin
                        m_rqt_q    <= 1'b0;
                        rsp_data_q <= m_data_rd_i;
                        rsp_err_q  <= 1'b0;
                        state_q    <= ST_DONE;
                    end else if (timeout_s) begin
                        m_rqt_q    <= 1'b0;
                        rsp_data_q <= 8'h00;
                        rsp_err_q  <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                ST_DONE: begin
                    req_ack_q    <= ONE_HOT0 << grant_q;
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    m_rqt_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack_o      = req_ack_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_err_o      = rsp_err_q;
    assign m_rqt_o        = m_rqt_q;
    assign m_cmd_o        = m_cmd_q;
    assign m_addr_dev_o   = m_addr_dev_q;
    assign m_addr_reg_h_o = m_addr_reg_q[15:8];
    assign m_addr_reg_l_o = m_addr_reg_q[7:0];
    assign m_data_wr_h_o  = m_data_wr_q[15:8];
    assign m_data_wr_l_o  = m_data_wr_q[7:0];
    assign busy_o         = busy_q;
    assign grant_id_o     = grant_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter (NREQ=3, TIMEOUT_CYC=100).
module tb_i2c_arbiter;
    import i2c_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_cmd;
    logic [7*NREQ-1:0] req_addr_dev;
    logic [16*NREQ-1:0] req_addr_reg;
    logic [16*NREQ-1:0] req_data_wr;
    logic [NREQ-1:0]   req_ack_o;
    logic [7:0]        rsp_data_o;
    logic              rsp_err_o;
    logic              m_rqt_o;
    logic              m_cmd_o;
    logic [6:0]        m_addr_dev_o;
    logic [7:0]        m_addr_reg_h_o;
    logic [7:0]        m_addr_reg_l_o;
    logic [7:0]        m_data_wr_h_o;
    logic [7:0]        m_data_wr_l_o;
    logic              m_done;
    logic [7:0]        m_data_rd;
    logic              busy_o;
    logic [1:0]        grant_id_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(24'd100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_cmd_i      (req_cmd),
        .req_addr_dev_i (req_addr_dev),
        .req_addr_reg_i (req_addr_reg),
        .req_data_wr_i  (req_data_wr),
        .req_ack_o      (req_ack_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_err_o      (rsp_err_o),
        .m_rqt_o        (m_rqt_o),
        .m_cmd_o        (m_cmd_o),
        .m_addr_dev_o   (m_addr_dev_o),
        .m_addr_reg_h_o (m_addr_reg_h_o),
        .m_addr_reg_l_o (m_addr_reg_l_o),
        .m_data_wr_h_o  (m_data_wr_h_o),
        .m_data_wr_l_o  (m_data_wr_l_o),
        .m_done_i       (m_done),
        .m_data_rd_i    (m_data_rd),
        .busy_o         (busy_o),
        .grant_id_o     (grant_id_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic cmd, input logic [6:0] dev,
                           input logic [15:0] rg, input logic [15:0] wr);
        req_cmd[i]               = cmd;
        req_addr_dev[7*i +: 7]   = dev;
        req_addr_reg[16*i +: 16] = rg;
        req_data_wr[16*i +: 16]  = wr;
    endtask

    // Master model: raises m_done once m_rqt is seen, drops it on the
    // drop_after-th cycle of m_rqt (0 = never), returns the ack-cycle view.
    task automatic run_master(input int drop_after, input logic [7:0] rd, input int mutate_at,
                              output int wait_cyc, output int hi, output logic [1:0] gid,
                              output logic [6:0] dev, output logic [NREQ-1:0] ack,
                              output logic [7:0] data, output logic err);
        int guard;
        wait_cyc = 0;
        hi       = 0;
        while (!m_rqt_o && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_eq("rqt_rise", m_rqt_o, 1);
        gid   = grant_id_o;
        dev   = m_addr_dev_o;
        guard = 0;
        while (m_rqt_o && guard < 400) begin
            hi++;
            if (hi == 1) m_done = 1'b1;
            if (drop_after != 0 && hi == drop_after) begin
                m_done    = 1'b0;
                m_data_rd = rd;
            end
            if (hi == mutate_at) begin
                req_valid[1] = 1'b0;
                set_req(1, CMD_READ, 7'h7F, 16'h0000, 16'h1111);
            end
            @(negedge clk);
            guard++;
        end
        check_eq("rqt_fall", m_rqt_o, 0);
        check_eq("ack_in_done", req_ack_o, 0);
        @(negedge clk);
        ack  = req_ack_o;
        data = rsp_data_o;
        err  = rsp_err_o;
    endtask

    initial begin
        int              wc, hi;
        logic [1:0]      gid;
        logic [6:0]      dev;
        logic [NREQ-1:0] ack;
        logic [7:0]      data;
        logic            err;
        logic [1:0]      order [4];
        logic [6:0]      devs [3];
        logic [NREQ-1:0] ack_seen;

        order = '{2'd0, 2'd1, 2'd2, 2'd0};
        devs  = '{7'h10, 7'h11, 7'h12};

        rst_n = 1'b0; req_valid = '0; req_cmd = '0; req_addr_dev = '0;
        req_addr_reg = '0; req_data_wr = '0; m_done = 1'b0; m_data_rd = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ack", req_ack_o, 0);
        check_eq("rst_rqt", m_rqt_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_gid", grant_id_o, 0);
        check_eq("rst_rsp", {23'd0, rsp_err_o, rsp_data_o}, 0);
        check_eq("rst_dev", m_addr_dev_o, 0);

        // Single READ from requester 0.
        set_req(0, CMD_READ, 7'h36, 16'h4D2A, 16'h0000);
        req_valid[0] = 1'b1;
        run_master(50, 8'h5A, 0, wc, hi, gid, dev, ack, data, err);
        check_eq("rd_latency", wc, 1);
        check_eq("rd_rqt_cycles", hi, 50);
        check_eq("rd_gid", gid, 0);
        check_eq("rd_dev", dev, 7'h36);
        check_eq("rd_reg", {m_addr_reg_h_o, m_addr_reg_l_o}, 16'h4D2A);
        check_eq("rd_cmd", m_cmd_o, 0);
        check_eq("rd_ack", ack, 3'b001);
        check_eq("rd_data", data, 8'h5A);
        check_eq("rd_err", err, 0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("rd_ack_pulse", req_ack_o, 0);
        check_eq("rd_idle", busy_o, 0);

        // Round-robin from reset state with all three requesting.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, CMD_WRITE, devs[i], 16'(i), 16'h0F00 + 16'(i));
        req_valid = 3'b111;
        for (int t = 0; t < 4; t++) begin
            run_master(5, 8'hC0 + 8'(t), 0, wc, hi, gid, dev, ack, data, err);
            if (t == 3) req_valid = '0;
            check_eq("rr_gid", gid, order[t]);
            check_eq("rr_dev", dev, devs[order[t]]);
            check_eq("rr_ack", ack, 3'b001 << order[t]);
            check_eq("rr_data", data, 8'hC0 + 8'(t));
            check_eq("rr_latency", wc, 1);
        end
        @(negedge clk);

        // Requester 1 changes its fields and drops valid mid-transaction.
        set_req(1, CMD_WRITE, 7'h21, 16'h1234, 16'hABCD);
        req_valid[1] = 1'b1;
        run_master(20, 8'h00, 3, wc, hi, gid, dev, ack, data, err);
        check_eq("mut_gid", gid, 1);
        check_eq("mut_ack", ack, 3'b010);
        check_eq("mut_dev", m_addr_dev_o, 7'h21);
        check_eq("mut_wr", {m_data_wr_h_o, m_data_wr_l_o}, 16'hABCD);
        check_eq("mut_reg", {m_addr_reg_h_o, m_addr_reg_l_o}, 16'h1234);
        check_eq("mut_cmd", m_cmd_o, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("mut_no_regrant", m_rqt_o, 0);

        // Timeout: master never releases m_done. rsp_data was 8'h00 above;
        // make it nonzero first with a quick read.
        set_req(2, CMD_READ, 7'h44, 16'h0001, 16'h0000);
        req_valid[2] = 1'b1;
        run_master(4, 8'hE7, 0, wc, hi, gid, dev, ack, data, err);
        check_eq("pre_to_data", data, 8'hE7);
        run_master(0, 8'h00, 0, wc, hi, gid, dev, ack, data, err);
        req_valid[2] = 1'b0;
        check_eq("to_rqt_cycles", hi, 100);
        check_eq("to_ack", ack, 3'b100);
        check_eq("to_err", err, 1);
        check_eq("to_data", data, 8'h00);
        m_done = 1'b0;
        repeat (2) @(negedge clk);

        // Falling edge in the same cycle as the timeout: completion wins.
        req_valid[0] = 1'b1;
        run_master(100, 8'h3C, 0, wc, hi, gid, dev, ack, data, err);
        req_valid[0] = 1'b0;
        check_eq("tie_rqt_cycles", hi, 100);
        check_eq("tie_err", err, 0);
        check_eq("tie_data", data, 8'h3C);
        repeat (2) @(negedge clk);

        // Stale m_done high on entry: only a later falling edge completes.
        m_done = 1'b1;
        repeat (2) @(negedge clk);
        req_valid[0] = 1'b1;
        run_master(20, 8'h99, 0, wc, hi, gid, dev, ack, data, err);
        req_valid[0] = 1'b0;
        check_eq("stale_rqt_cycles", hi, 20);
        check_eq("stale_data", data, 8'h99);
        repeat (2) @(negedge clk);

        // Reset asserted 10 cycles into ISSUE.
        req_valid[2] = 1'b1;
        @(negedge clk);
        check_eq("rstm_rqt_up", m_rqt_o, 1);
        m_done = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rstm_rqt", m_rqt_o, 0);
        check_eq("rstm_busy", busy_o, 0);
        req_valid = '0;
        m_done    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        ack_seen = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ack_seen = ack_seen | req_ack_o;
        end
        check_eq("rstm_no_ack", ack_seen, 0);
        check_eq("rstm_idle", busy_o, 0);
        check_eq("rstm_gid", grant_id_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing one I2C master (2..4).
REQ-002 Parameter TIMEOUT_CYC, default 24'd1_000_000, maximum clk cycles allowed for one transaction.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester transaction request, level, held until its req_ack.
REQ-006 req_cmd  input  NREQ  per-requester command, 1 = WRITE, 0 = READ.
REQ-007 req_addr_dev  input  7*NREQ  per-requester 7-bit device address, slice i = [7i+6:7i].
REQ-008 req_addr_reg  input  16*NREQ  per-requester register address {H,L}.
REQ-009 req_data_wr  input  16*NREQ  per-requester write data {H,L}.
REQ-010 req_ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 rsp_data  output  8  read data, valid in the req_ack cycle.
REQ-012 rsp_err  output  1  timeout flag, valid in the req_ack cycle.
REQ-013 m_rqt  output  1  request to I2C master; m_cmd/m_addr_dev/m_addr_reg_H/L/m_data_wr_H/L outputs carry latched fields.
REQ-014 m_done  input  1  master done; completion is the falling edge of m_done.
REQ-015 m_data_rd  input  8  master read data, valid at m_done falling edge.
REQ-016 busy  output  1  high in any state except IDLE; grant_id  output  2  index of current owner.

Function
REQ-017 FSM states: IDLE, ISSUE, DONE; one-hot or binary encoding permitted.
REQ-018 IDLE: if any req_valid set, select winner round-robin starting at (last_grant+1) mod NREQ; latch winner's fields into output registers, set grant_id, enter ISSUE next cycle.
REQ-019 ISSUE: m_rqt = 1; timeout counter increments each cycle from 0.
REQ-020 m_done falling edge detected with a registered m_done copy (prev=1, now=0); on detection: m_rqt <= 0, capture m_data_rd into rsp_data, rsp_err <= 0, enter DONE.
REQ-021 Timeout: counter reaching TIMEOUT_CYC-1 in ISSUE with no falling edge: m_rqt <= 0, rsp_err <= 1, rsp_data <= 8'h00, enter DONE.
REQ-022 Falling edge and timeout in same cycle: falling edge wins, rsp_err = 0.
REQ-023 DONE: req_ack[grant_id] = 1 for exactly one cycle, last_grant <= grant_id, return to IDLE; next grant earliest one cycle after DONE.
REQ-024 Latency: grant to m_rqt high = 1 cycle from req_valid seen in IDLE; m_done fall to req_ack = 2 cycles.
REQ-025 Latched fields SHALL not change while busy; requester input changes during ISSUE ignored.
REQ-026 req_valid dropped mid-transaction: transaction completes, req_ack still pulsed.
REQ-027 Requester holding req_valid after ack is rearbitrated normally; round-robin guarantees every asserting requester a grant within NREQ transactions.
REQ-028 m_done high on entry to ISSUE (stale): no completion until a falling edge occurs.

Reset
REQ-029 rst_n low: state IDLE, m_rqt 0, req_ack 0, rsp_data 0, rsp_err 0, busy 0, grant_id 0, last_grant NREQ-1, counter 0, all m_* fields 0; applies immediately, including mid-transaction.

Structure
REQ-030 Shared package holds WRITE=1/READ=0, FSM state encodings, default TIMEOUT_CYC.
REQ-031 One sub-module natural: i2c_rr_picker (combinational round-robin select, inputs req vector and last_grant, outputs winner and any_valid).

Verification
REQ-032 Single READ from req 0 (dev 7'h36, reg 16'h4D2A); master model drops m_done after 50 cycles with data 8'h5A -> m_rqt high 50 cycles, req_ack[0] pulse with rsp_data 8'h5A, rsp_err 0.
REQ-033 req 0,1,2 asserted together, reset state -> grants in order 0,1,2, then 0 again if still asserted.
REQ-034 Master never drops m_done, TIMEOUT_CYC=100 -> m_rqt falls after 100 cycles in ISSUE, req_ack with rsp_err 1, rsp_data 8'h00.
REQ-035 req 1 WRITE 16'hABCD; req 1 changes its fields and drops req_valid during ISSUE -> master sees original fields, req_ack[1] still pulses.
REQ-036 rst_n asserted 10 cycles into ISSUE -> m_rqt 0 same cycle, no req_ack, FSM in IDLE on release.
